// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//
// Pushbutton conditioner. Each raw button pin is polarity-normalised
// (1 = pressed), passed through a two-flop synchroniser and debounced: a new
// level is accepted only once it has been seen on every clock of a run of
// DEBOUNCE_CYCLES. Clean level, press/release strobes, a one-shot long-press
// strobe and a wrapping 3-bit press counter for one chosen channel are
// produced. Every output comes straight from a flop.
//
// Ports
//   clk            system clock, single domain
//   rst            synchronous active-high reset
//   btn_raw        raw asynchronous button pins
//   btn_state      debounced level per channel, 1 = pressed
//   press_pulse    one-cycle strobe when btn_state rises
//   release_pulse  one-cycle strobe when btn_state falls
//   long_pulse     one-cycle strobe once per press after LONG_CYCLES held
//   press_count    presses seen on channel COUNT_CH, modulo 8
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned LONG_CYCLES     = 12000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned COUNT_CH        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [2:0]       press_count
);

  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned LW  = $clog2(LONG_CYCLES + 1);

  // Last count value of a debounce run; reaching it with the new level still
  // present means the level has been stable for DEBOUNCE_CYCLES clocks.
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0]  LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0]  LONG_MAX  = LW'(LONG_CYCLES);

  // Polarity is fixed before synchronisation so everything downstream uses
  // 1 = pressed.
  logic [N_BTN-1:0] w_pressed;
  assign w_pressed = ACTIVE_LOW ? ~btn_raw : btn_raw;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] r_state;
  logic [N_BTN-1:0] r_press_pulse;
  logic [N_BTN-1:0] r_release_pulse;
  logic [N_BTN-1:0] r_long_pulse;
  logic [2:0]       r_press_count;
  logic [DBW-1:0]   r_db_cnt   [N_BTN];
  logic [LW-1:0]    r_long_cnt [N_BTN];

  // NOTE: all state here is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours (r_sync2 reads the old
  // r_sync1, the long counter reads the old r_state), matching real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1         <= '0;
      r_sync2         <= '0;
      r_state         <= '0;
      r_press_pulse   <= '0;
      r_release_pulse <= '0;
      r_long_pulse    <= '0;
      r_press_count   <= '0;
      // NOTE: the counter arrays are only N_BTN entries of flops, not a RAM,
      // so resetting them is cheap and guarantees no stale debounce progress.
      for (int i = 0; i < N_BTN; i++) begin
        r_db_cnt[i]   <= '0;
        r_long_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_pressed;
      r_sync2 <= r_sync1;

      // Counts the registered strobe, so the count moves the cycle after the
      // press_pulse on COUNT_CH is visible. Wraps naturally at 3 bits.
      r_press_count <= r_press_count + 3'(r_press_pulse[COUNT_CH]);

      for (int i = 0; i < N_BTN; i++) begin
        r_press_pulse[i]   <= 1'b0;
        r_release_pulse[i] <= 1'b0;

        // Any sample matching the accepted level restarts the run, so partial
        // progress from a bounce is never kept.
        if (r_sync2[i] == r_state[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_state[i]         <= r_sync2[i];
          r_db_cnt[i]        <= '0;
          r_press_pulse[i]   <= r_sync2[i];
          r_release_pulse[i] <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end

        // Strobe on the edge where the hold count steps onto LONG_CYCLES;
        // the count then saturates so there is one strobe per press.
        r_long_pulse[i] <= r_state[i] && (r_long_cnt[i] == LONG_LAST);
        if (!r_state[i]) begin
          r_long_cnt[i] <= '0;
        end else if (r_long_cnt[i] != LONG_MAX) begin
          r_long_cnt[i] <= r_long_cnt[i] + LW'(1);
        end
      end
    end
  end

  assign btn_state     = r_state;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign long_pulse    = r_long_pulse;
  assign press_count   = r_press_count;

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Pushbutton input conditioner for the board GPIO, the input-side counterpart of the LED blinker output path. It takes up to N_BTN raw mechanical button pins, synchronises and debounces them, and emits clean level, press, release and long-press indications. It also maintains a wrapping 3-bit press counter that can drive the 3-bit LED bank directly.

## Interface
- N_BTN, 3: number of button channels (1..8)
- DEBOUNCE_CYCLES, 240000: cycles a new level must be stable before acceptance (20 ms at 12 MHz); minimum 2
- LONG_CYCLES, 12000000: cycles held pressed before long-press fires (1 s at 12 MHz); must be > DEBOUNCE_CYCLES
- ACTIVE_LOW, 1: 1 = pin low means pressed; 0 = pin high means pressed
- COUNT_CH, 0: channel whose presses drive press_count
- clk  input  1  system clock, single clock domain
- rst  input  1  synchronous, active-high reset
- btn_raw  input  N_BTN  asynchronous raw button pins
- btn_state  output  N_BTN  debounced level, 1 = pressed (polarity-normalised)
- press_pulse  output  N_BTN  1-cycle strobe when btn_state rises
- release_pulse  output  N_BTN  1-cycle strobe when btn_state falls
- long_pulse  output  N_BTN  1-cycle strobe once per press after LONG_CYCLES held
- press_count  output  3  count of COUNT_CH presses, mod 8

## Operation
- Per channel, fully independent; no shared arbitration.
- Polarity: raw is inverted when ACTIVE_LOW=1 before synchronisation, so all internal logic uses 1 = pressed.
- Synchroniser: 2 flops, sync1 then sync2; only sync2 feeds debounce.
- Debounce counter, width ceil(log2(DEBOUNCE_CYCLES)):
  - sync2 == btn_state: counter cleared to 0.
  - sync2 != btn_state and counter < DEBOUNCE_CYCLES-1: counter += 1.
  - sync2 != btn_state and counter == DEBOUNCE_CYCLES-1: btn_state <= sync2, counter <= 0, and the matching press_pulse or release_pulse is registered high for the next cycle only.
- Any glitch back to the accepted level before acceptance clears the counter; partial progress is never retained.
- Long-press counter, width ceil(log2(LONG_CYCLES+1)):
  - Cleared while btn_state = 0.
  - Increments while btn_state = 1 and the count is < LONG_CYCLES.
  - long_pulse is high for exactly the one cycle in which the count transitions to LONG_CYCLES.
  - The counter then saturates, so only one long_pulse fires per press.
- press_count increments by 1 on each press_pulse[COUNT_CH] and wraps 7 -> 0. Other channels do not affect it.

## Timing
- Reset (rst=1 at a clk edge):
  - btn_state, press_pulse, release_pulse, long_pulse = 0; press_count = 0.
  - All counters = 0.
  - Sync flops load the released level (0 after polarity normalisation).
- Latency: raw stable from before edge E1 → btn_state and the pulse change after edge E(DEBOUNCE_CYCLES+2). Two synchroniser edges, then DEBOUNCE_CYCLES counting edges.
- press_pulse/release_pulse are high in the same cycle btn_state first shows the new value.
- long_pulse asserts LONG_CYCLES cycles after btn_state rises.
- Release during a pending long count: counter clears and no long_pulse fires.
- Release in the same cycle the long count would complete: btn_state is still 1 for that cycle, so long_pulse fires, followed by a normal release debounce.
- Simultaneous events on several channels: each channel pulses independently in the same cycle.
- Reset mid-debounce or mid-hold: all progress is discarded. A button held through reset is re-detected as a new press DEBOUNCE_CYCLES+2 cycles after rst deasserts, giving press_pulse and press_count += 1.
- All outputs are registered; there is no combinational path from btn_raw to any output.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1, N_BTN=3.

- Clean press: btn_raw[0] 1→0 and held → btn_state[0]=1 and press_pulse[0] for 1 cycle, 6 edges after the change; press_count=1.
- Bounce: btn_raw[1] low for 3 cycles, high 1, low 2, then high → btn_state[1] stays 0; no pulses.
- Long press: hold btn_raw[2] low for 40 cycles → press_pulse at edge 6, long_pulse exactly once 16 cycles later; release_pulse 6 edges after the pin returns high.
- Wrap and simultaneity: 9 clean presses on ch0, the 9th concurrent with a ch1 press → press_count sequence 1..7,0,1; both press_pulse bits high in the same cycle; ch1 does not change press_count.
- Reset mid-operation: assert rst 2 cycles into a ch0 debounce and again during a 10-cycle hold → all outputs 0 the cycle after reset. With the pin still low, press_pulse[0] fires 6 edges after rst deasserts and long_pulse fires 16 cycles later.
